// File: rtl/bios_boot_loader_if.sv
// rtl/bios_boot_loader_if.sv - BIOS ROM, code-memory and CPU-control signals of the boot loader
interface bios_boot_loader_if #(
   parameter int CM_ADDR_W = 5
);
   logic [3:0]           bios_addr;
   logic [15:0]          bios_data;
   logic                 cm_wr_en;
   logic                 cm_wr_ready;
   logic [CM_ADDR_W-1:0] cm_wr_addr;
   logic [15:0]          cm_wr_data;
   logic [CM_ADDR_W-1:0] cm_rd_addr;
   logic [15:0]          cm_rd_data;
   logic                 reload;
   logic                 cpu_hold;
   logic                 done;
   logic                 error;
   logic [3:0]           err_index;

   modport master (
      output bios_addr, cm_wr_en, cm_wr_addr, cm_wr_data, cm_rd_addr,
             cpu_hold, done, error, err_index,
      input  bios_data, cm_wr_ready, cm_rd_data, reload
   );

   modport slave (
      input  bios_addr, cm_wr_en, cm_wr_addr, cm_wr_data, cm_rd_addr,
             cpu_hold, done, error, err_index,
      output bios_data, cm_wr_ready, cm_rd_data, reload
   );
endinterface

// File: rtl/bios_boot_loader.sv
// rtl/bios_boot_loader.sv - copies the BIOS image into code memory, optionally verifies it, then releases the CPU
module bios_boot_loader #(
   parameter int NUM_WORDS = 16,
   parameter int BASE_ADDR = 0,
   parameter int CM_ADDR_W = 5,
   parameter int VERIFY    = 1
) (
   input  logic               clock,
   input  logic               reset,
   bios_boot_loader_if.master bus
);
   typedef enum logic [2:0] {
      S_INIT, S_WRITE, S_RD, S_CHK, S_DONE, S_ERROR
   } state_t;

   localparam logic [3:0]           LAST_IDX = 4'(NUM_WORDS - 1);
   localparam logic [CM_ADDR_W-1:0] BASE     = CM_ADDR_W'(BASE_ADDR);

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_idx;
   logic [3:0]           w_idx_next;
   logic [3:0]           r_err_index;
   logic [3:0]           w_err_index_next;
   logic [CM_ADDR_W-1:0] w_addr;

   // Code-memory address wraps naturally at 2^CM_ADDR_W
   assign w_addr = BASE + CM_ADDR_W'(r_idx);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_idx       <= '0;
         r_err_index <= '0;
      end else begin
         r_state     <= w_next;
         r_idx       <= w_idx_next;
         r_err_index <= w_err_index_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      w_idx_next       = r_idx;
      w_err_index_next = r_err_index;
      case (r_state)
         S_INIT: begin
            w_idx_next       = '0;
            w_err_index_next = '0;
            w_next           = S_WRITE;
         end
         S_WRITE: begin
            if (bus.cm_wr_ready) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_next = '0;
                  w_next     = (VERIFY != 0) ? S_RD : S_DONE;
               end else begin
                  w_idx_next = r_idx + 4'd1;
               end
            end
         end
         S_RD: w_next = S_CHK;
         S_CHK: begin
            // Read data was launched by the address presented in S_RD
            if (bus.cm_rd_data != bus.bios_data) begin
               w_err_index_next = r_idx;
               w_next           = S_ERROR;
            end else if (r_idx == LAST_IDX) begin
               w_next = S_DONE;
            end else begin
               w_idx_next = r_idx + 4'd1;
               w_next     = S_RD;
            end
         end
         S_DONE, S_ERROR: begin
            if (bus.reload) w_next = S_INIT;
         end
         default: w_next = S_INIT;
      endcase
   end

   assign bus.bios_addr  = r_idx;
   assign bus.cm_wr_en   = (r_state == S_WRITE);
   assign bus.cm_wr_addr = w_addr;
   assign bus.cm_wr_data = bus.bios_data;
   assign bus.cm_rd_addr = (VERIFY != 0) ? w_addr : BASE;
   assign bus.cpu_hold   = (r_state != S_DONE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.error      = (r_state == S_ERROR);
   assign bus.err_index  = r_err_index;
endmodule

// File: tb/tb_bios_boot_loader.sv
// tb/tb_bios_boot_loader.sv - self-checking bench for bios_boot_loader over four parameter sets
module tb_bios_boot_loader;
   localparam int NI = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [NI];
   logic        rdy     [NI];
   logic        rel     [NI];
   logic        corrupt [NI];
   logic        o_wren  [NI];
   logic        o_hold  [NI];
   logic        o_done  [NI];
   logic        o_err   [NI];
   logic [4:0]  o_wr_addr   [NI];
   logic [4:0]  o_rd_addr   [NI];
   logic [15:0] o_wr_data   [NI];
   logic [3:0]  o_bios_addr [NI];
   logic [3:0]  o_err_idx   [NI];

   int start_gen [NI];
   int exp_lit   [NI];
   int n_timeout = 0;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic int nw(input int i);
      return (i == 3) ? 1 : 16;
   endfunction
   function automatic int base(input int i);
      return (i == 2) ? 20 : 0;
   endfunction
   function automatic int ver(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic logic [15:0] rom(input int k);
      case (k)
         0:       return 16'h5C10;
         6:       return 16'hC0FA;
         15:      return 16'h0000;
         default: return 16'(32'h1000 + k * 32'h0123);
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int P_NW   = (g == 3) ? 1 : 16;
      localparam int P_BASE = (g == 2) ? 20 : 0;
      localparam int P_VER  = (g == 1) ? 0 : 1;

      bios_boot_loader_if #(.CM_ADDR_W(5)) bif ();
      logic [15:0] mem [32];

      bios_boot_loader #(
         .NUM_WORDS(P_NW), .BASE_ADDR(P_BASE), .CM_ADDR_W(5), .VERIFY(P_VER)
      ) u_dut (
         .clock(clk),
         .reset(rst[g]),
         .bus  (bif.master)
      );

      assign bif.bios_data   = rom(int'(bif.bios_addr));
      assign bif.cm_wr_ready = rdy[g];
      assign bif.reload      = rel[g];
      assign o_wren[g]       = bif.cm_wr_en;
      assign o_hold[g]       = bif.cpu_hold;
      assign o_done[g]       = bif.done;
      assign o_err[g]        = bif.error;
      assign o_wr_addr[g]    = bif.cm_wr_addr;
      assign o_rd_addr[g]    = bif.cm_rd_addr;
      assign o_wr_data[g]    = bif.cm_wr_data;
      assign o_bios_addr[g]  = bif.bios_addr;
      assign o_err_idx[g]    = bif.err_index;

      // Code-memory RAM with an optional stuck write at address 9
      always @(posedge clk) begin
         if (bif.cm_wr_en && bif.cm_wr_ready)
            mem[bif.cm_wr_addr] <= (corrupt[g] && bif.cm_wr_addr == 5'd9) ?
                                   ~bif.cm_wr_data : bif.cm_wr_data;
         bif.cm_rd_data <= mem[bif.cm_rd_addr];
      end
   end

   int run_edge [NI];
   int wr_cnt   [NI];
   int stall    [NI];
   int seen_gen [NI];
   bit run_corrupt [NI];
   bit prev_done   [NI];
   int seen_to = 0;

   task automatic chk(input string name, input int i, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d edge=%0d: got 0x%0h, want 0x%0h", name, i, run_edge[i], act, exp);
      end
   endtask

   // Model: a run is 1 INIT edge, one accepted write per word (plus one edge per stall),
   // then two edges per verified word; a corrupted word 9 stops verification there.
   always @(negedge clk) begin : p_cmp
      int  tot;
      bit  e_done, e_err, e_wr;
      if (n_timeout != seen_to) begin
         chk("wait_bound", 0, n_timeout, seen_to);
         seen_to = n_timeout;
      end
      for (int i = 0; i < NI; i++) begin
         if (rst[i]) begin
            chk("rst_wren", i, o_wren[i], 0);
            chk("rst_hold", i, o_hold[i], 1);
            chk("rst_done", i, o_done[i], 0);
            chk("rst_err", i, o_err[i], 0);
            chk("rst_err_idx", i, o_err_idx[i], 0);
            chk("rst_bios_addr", i, o_bios_addr[i], 0);
            chk("rst_wr_addr", i, o_wr_addr[i], base(i));
            chk("rst_rd_addr", i, o_rd_addr[i], base(i));
         end else if (start_gen[i] != 0) begin
            if (seen_gen[i] != start_gen[i]) begin
               seen_gen[i]    = start_gen[i];
               run_edge[i]    = 0;
               wr_cnt[i]      = 0;
               stall[i]       = 0;
               run_corrupt[i] = corrupt[i];
            end
            tot    = 1 + nw(i) + stall[i] + (ver(i) != 0 ? 2 * nw(i) : 0);
            e_err  = run_corrupt[i] && (run_edge[i] >= 1 + nw(i) + stall[i] + 2 * 10);
            e_done = !run_corrupt[i] && (run_edge[i] >= tot);
            e_wr   = (run_edge[i] >= 1) && (wr_cnt[i] < nw(i));

            chk("done", i, o_done[i], e_done);
            chk("error", i, o_err[i], e_err);
            chk("cpu_hold", i, o_hold[i], !e_done);
            chk("wr_en", i, o_wren[i], e_wr);
            if (e_err) chk("err_index", i, o_err_idx[i], 9);
            if (e_wr) begin
               chk("wr_addr", i, o_wr_addr[i], (base(i) + wr_cnt[i]) % 32);
               chk("wr_data", i, o_wr_data[i], rom(wr_cnt[i]));
               chk("bios_addr", i, o_bios_addr[i], wr_cnt[i]);
            end
            if (ver(i) == 0) chk("rd_addr_fixed", i, o_rd_addr[i], base(i));

            if (o_done[i] && !prev_done[i]) begin
               chk("done_edge", i, run_edge[i], exp_lit[i]);
               chk("writes_total", i, wr_cnt[i], nw(i));
            end
            if (i == 0 && e_wr && wr_cnt[i] == 0) chk("word0", i, o_wr_data[i], 16'h5C10);
            if (i == 0 && e_wr && wr_cnt[i] == 6) chk("word6", i, o_wr_data[i], 16'hC0FA);
            if (i == 2 && e_wr && wr_cnt[i] == 12) chk("wrap_addr", i, o_wr_addr[i], 0);

            if (e_wr) begin
               if (rdy[i]) wr_cnt[i]++;
               else        stall[i]++;
            end
            if (rel[i] && (e_done || e_err)) begin
               run_edge[i]    = 0;
               wr_cnt[i]      = 0;
               stall[i]       = 0;
               run_corrupt[i] = corrupt[i];
            end else begin
               run_edge[i]++;
            end
         end
         prev_done[i] = o_done[i];
      end
   end

   task automatic wait_end(input int i, input int budget);
      int c = 0;
      while (!(o_done[i] || o_err[i]) && c < budget) begin
         @(posedge clk); #1; c++;
      end
      if (c >= budget) n_timeout++;
   endtask

   task automatic wait_addr(input int i, input logic [4:0] a, input int budget);
      int c = 0;
      while (!(o_wren[i] && o_wr_addr[i] == a) && c < budget) begin
         @(posedge clk); #1; c++;
      end
      if (c >= budget) n_timeout++;
   endtask

   task automatic pulse_reload(input int i);
      rel[i] = 1'b1;
      @(posedge clk); #1;
      rel[i] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1; rdy[i] = 1'b1; rel[i] = 1'b0; corrupt[i] = 1'b0;
         start_gen[i] = 0;
      end
      exp_lit = '{49, 17, 49, 4};
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b0;
         start_gen[i]++;
      end
      wait_end(0, 80);
      repeat (2) @(posedge clk);
      #1;

      // Reload from DONE, reload pulse ignored mid-write, 3-cycle stall at idx 4
      exp_lit[0] = 52;
      pulse_reload(0);
      wait_addr(0, 5'd2, 20);
      pulse_reload(0);
      wait_addr(0, 5'd4, 20);
      rdy[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rdy[0] = 1'b1;
      wait_end(0, 80);
      repeat (2) @(posedge clk);
      #1;

      // Corrupted write at address 9, then recovery by reload
      corrupt[0] = 1'b1;
      pulse_reload(0);
      wait_end(0, 80);
      repeat (3) @(posedge clk);
      #1;
      corrupt[0] = 1'b0;
      exp_lit[0] = 49;
      pulse_reload(0);
      wait_end(0, 80);
      repeat (2) @(posedge clk);
      #1;

      // Reset asserted in the middle of the write phase
      pulse_reload(0);
      wait_addr(0, 5'd7, 20);
      rst[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      start_gen[0]++;
      wait_end(0, 80);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
